set_assoc_cache_store: RTL and testbench
========================================

# set_assoc_cache_store

Parametrised N-way set-associative tag/data store with LRU replacement. It is the successor to the direct-mapped lookup/update block in the cache simulator core. It takes explicit address ports instead of hierarchical references and reports the hit way, the hit data and the evicted line. It keeps hit/miss statistics for the simulator front end and sits between the request sequencer and the main-memory block fetcher.

## Interface
- ADDR_BITS, 32, byte address width
- BLOCK_BYTES, 16, line size in bytes (power of 2); OFFSET_BITS = log2(BLOCK_BYTES)
- INDEX_BITS, 7, set index width; SETS = 2**INDEX_BITS
- WAYS, 4, associativity (power of 2, ≥1); WAY_BITS = max(1, log2(WAYS))
- TAG_BITS, derived, ADDR_BITS-INDEX_BITS-OFFSET_BITS (21 at defaults)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- ready  out  1  store idle, request may be accepted
- find_start  in  1  lookup request, held until accepted
- find_addr  in  ADDR_BITS  lookup address
- update_start  in  1  fill request, held until accepted
- update_addr  in  ADDR_BITS  fill address
- block  in  BLOCK_BYTES*8  fill data
- done  out  1  one-cycle pulse: lookup result valid
- found_in_cache  out  1  lookup hit (qualified by done)
- hit_way  out  WAY_BITS  way that hit
- hit_data  out  BLOCK_BYTES*8  line data on hit, 0 on miss
- updated  out  1  one-cycle pulse: fill written
- evict_valid  out  1  fill displaced a valid line (qualified by updated)
- evict_tag  out  TAG_BITS  tag of displaced line
- cache_hit_count  out  16  saturating hit counter
- cache_miss_count  out  16  saturating miss counter

## Operation
- Address split: offset = addr[OFFSET_BITS-1:0]; index = the next INDEX_BITS bits; tag = the top TAG_BITS.
- Per-line storage: valid bit, tag, data. Only the valid bits are reset; tag and data are not.
- Per-set LRU state: one WAY_BITS age per way, holding a permutation of 0..WAYS-1. 0 = most recent.
- FSM states: IDLE, LOOKUP, FILL. ready = (state==IDLE).
- Acceptance in IDLE:
  - update_start wins over find_start and moves the FSM to FILL.
  - Otherwise find_start moves the FSM to LOOKUP.
  - Address and block are captured on acceptance. An unaccepted find stays pending while held.
- LOOKUP:
  - All ways are compared in parallel.
  - Hit = valid && tag match, lowest way on a multi-match. On a hit: found_in_cache=1, hit_way and hit_data set, LRU touched, hit count +1.
  - Otherwise: found_in_cache=0, hit_data=0, miss count +1. A valid line with a mismatched tag counts as a miss.
  - done pulses and the FSM returns to IDLE.
- FILL:
  - Target way is chosen in this order: the way whose tag already matches and is valid (no eviction); else the lowest invalid way; else the way with age WAYS-1.
  - Valid, tag and data are written. The LRU is touched.
  - evict_valid/evict_tag are set only when a valid line with a different tag is replaced.
  - updated pulses and the FSM returns to IDLE.
- LRU touch of way w with old age a: w gets age 0; every way with age < a gets +1; the others are unchanged.
- Counters saturate at 0xFFFF and never wrap.
- WAYS=1 degenerates to direct-mapped: hit_way=0 always, and the LRU has no effect.

## Timing
- Request accepted at edge T. Result registered at edge T+1. done/updated are high for the cycle after T+1, with ready high in that same cycle, so back-to-back requests issue every 2 cycles.
- found_in_cache, hit_way, hit_data, evict_valid and evict_tag hold their values until the next result of the same kind.
- Reset value of every output is 0, except ready, which is 1.
- Reset state:
  - All valid bits are 0.
  - LRU ages are reset to the way index.
  - Counters are 0 and the FSM is in IDLE.
- Reset asserted mid-request aborts the request. Neither done nor updated pulses, and no array write occurs.
- A find to the same set immediately after an update sees the updated line.

## Structure
- Package cache_store_pkg holds:
  - the state enum (IDLE/LOOKUP/FILL);
  - a clog2 function;
  - derived localparam helpers for OFFSET_BITS, TAG_BITS and WAY_BITS.
- Sub-module cache_lru_ages:
  - per-set age array with reset;
  - inputs: touch_en, touch_set, touch_way;
  - outputs: the ages of a read set and the victim way.
- The top level holds the FSM, the tag/data/valid arrays, compare/select logic and the counters.

## Test plan
Default parameters. Addresses 0x1230, 0x1A30, 0x2230, 0x2A30 and 0x3230 all map to index 0x23 with tags 2..6.
- Cold find 0x1230 after reset → done at T+1, found=0, miss=1, hit=0.
- Update 0x1230 with data 0xAA..AA, then find 0x1230 → updated with evict_valid=0; find gives found=1, hit_way=0, hit_data=0xAA..AA, hit=1.
- Fill tags 2..5 into ways 0..3, find 0x1230, then update 0x3230 → way 1 (tag 3) replaced, evict_valid=1, evict_tag=3. A later find of 0x1A30 misses.
- find_start and update_start asserted together in IDLE → update served first; find served on the next acceptance with the correct result.
- Drop rst_n during LOOKUP → all outputs 0 except ready=1, no done pulse, counters 0, all lines invalid.
- Force 0xFFFF misses → cache_miss_count stays 0xFFFF on the next miss.

Source files
------------

// File: rtl/cache_store_pkg.sv
// Shared state encoding and parameter-derivation helpers for the
// set-associative cache store and its LRU sub-block.
package cache_store_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int offset_bits(input int block_bytes);
        return clog2(block_bytes);
    endfunction

    function automatic int tag_bits(input int addr_bits, input int index_bits, input int block_bytes);
        return addr_bits - index_bits - clog2(block_bytes);
    endfunction

    // A direct-mapped store still carries a one-bit way number.
    function automatic int way_bits(input int ways);
        return (ways > 1) ? clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/cache_lru_ages.sv
// Per-set LRU age table: each set holds a permutation of ages, 0 = most recent.
// Reports the oldest way of the addressed set as the replacement victim.
module cache_lru_ages
    import cache_store_pkg::*;
#(
    parameter int SETS       = 128,
    parameter int INDEX_BITS = 7,
    parameter int WAYS       = 4,
    parameter int WAY_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  touch_en,
    input  logic [INDEX_BITS-1:0] touch_set,
    input  logic [WAY_BITS-1:0]   touch_way,
    input  logic [INDEX_BITS-1:0] read_set,
    output logic [WAY_BITS-1:0]   victim_way
);

    logic [WAY_BITS-1:0] ages [SETS][WAYS];
    logic [WAY_BITS-1:0] touched_age;

    assign touched_age = ages[touch_set][touch_way];

    // Touched way becomes youngest; only ways younger than it age by one,
    // which keeps every set's ages a permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ages[s][w] <= WAY_BITS'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(touch_way)) begin
                    ages[touch_set][w] <= '0;
                end else if (ages[touch_set][w] < touched_age) begin
                    ages[touch_set][w] <= ages[touch_set][w] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[read_set][w] == WAY_BITS'(WAYS - 1)) begin
                victim_way = WAY_BITS'(w);
            end
        end
    end

endmodule

// File: rtl/set_assoc_cache_store.sv
// N-way set-associative tag/data store with LRU replacement, explicit
// lookup/fill request ports, eviction reporting and saturating hit/miss counters.
module set_assoc_cache_store
    import cache_store_pkg::*;
#(
    parameter int ADDR_BITS   = 32,
    parameter int BLOCK_BYTES = 16,
    parameter int INDEX_BITS  = 7,
    parameter int WAYS        = 4,
    localparam int OFFSET_BITS = offset_bits(BLOCK_BYTES),
    localparam int TAG_BITS    = tag_bits(ADDR_BITS, INDEX_BITS, BLOCK_BYTES),
    localparam int WAY_BITS    = way_bits(WAYS),
    localparam int DATA_BITS   = BLOCK_BYTES * 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 ready,
    input  logic                 find_start,
    input  logic [ADDR_BITS-1:0] find_addr,
    input  logic                 update_start,
    input  logic [ADDR_BITS-1:0] update_addr,
    input  logic [DATA_BITS-1:0] block,
    output logic                 done,
    output logic                 found_in_cache,
    output logic [WAY_BITS-1:0]  hit_way,
    output logic [DATA_BITS-1:0] hit_data,
    output logic                 updated,
    output logic                 evict_valid,
    output logic [TAG_BITS-1:0]  evict_tag,
    output logic [15:0]          cache_hit_count,
    output logic [15:0]          cache_miss_count
);

    localparam int SETS = 1 << INDEX_BITS;

    state_e                state;
    logic [INDEX_BITS-1:0] req_index;
    logic [TAG_BITS-1:0]   req_tag;
    logic [DATA_BITS-1:0]  req_block;

    logic [WAYS-1:0]       valid      [SETS];
    logic [TAG_BITS-1:0]   tags       [SETS][WAYS];
    logic [DATA_BITS-1:0]  data_array [SETS][WAYS];

    logic                  hit_any;
    logic [WAY_BITS-1:0]   hit_sel;
    logic                  invalid_any;
    logic [WAY_BITS-1:0]   invalid_sel;
    logic [WAY_BITS-1:0]   victim_way;
    logic [WAY_BITS-1:0]   fill_way;
    logic                  evicting;
    logic                  touch_en;
    logic [WAY_BITS-1:0]   touch_way;
    logic                  unused_offset_bits;

    // Byte offsets select nothing inside a whole-line store.
    assign unused_offset_bits = ^{find_addr[OFFSET_BITS-1:0], update_addr[OFFSET_BITS-1:0]};

    assign ready = (state == IDLE);

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit_any     = 1'b0;
        hit_sel     = '0;
        invalid_any = 1'b0;
        invalid_sel = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid[req_index][w] && (tags[req_index][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_sel = w[WAY_BITS-1:0];
            end
            if (!valid[req_index][w]) begin
                invalid_any = 1'b1;
                invalid_sel = w[WAY_BITS-1:0];
            end
        end
    end

    assign fill_way  = hit_any ? hit_sel : (invalid_any ? invalid_sel : victim_way);
    assign evicting  = !hit_any && !invalid_any;
    assign touch_en  = ((state == LOOKUP) && hit_any) || (state == FILL);
    assign touch_way = (state == LOOKUP) ? hit_sel : fill_way;

    cache_lru_ages #(
        .SETS       (SETS),
        .INDEX_BITS (INDEX_BITS),
        .WAYS       (WAYS),
        .WAY_BITS   (WAY_BITS)
    ) u_lru (
        .clk        (clk),
        .rst_n      (rst_n),
        .touch_en   (touch_en),
        .touch_set  (req_index),
        .touch_way  (touch_way),
        .read_set   (req_index),
        .victim_way (victim_way)
    );

    // Tag and data are never reset; a reset mid-fill leaves the FSM in IDLE
    // so no write can slip through.
    always_ff @(posedge clk) begin
        if (state == FILL) begin
            tags[req_index][fill_way]       <= req_tag;
            data_array[req_index][fill_way] <= req_block;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            req_index        <= '0;
            req_tag          <= '0;
            req_block        <= '0;
            done             <= 1'b0;
            updated          <= 1'b0;
            found_in_cache   <= 1'b0;
            hit_way          <= '0;
            hit_data         <= '0;
            evict_valid      <= 1'b0;
            evict_tag        <= '0;
            cache_hit_count  <= '0;
            cache_miss_count <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid[s] <= '0;
            end
        end else begin
            done    <= 1'b0;
            updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (update_start) begin
                        state     <= FILL;
                        req_index <= update_addr[OFFSET_BITS +: INDEX_BITS];
                        req_tag   <= update_addr[ADDR_BITS-1 -: TAG_BITS];
                        req_block <= block;
                    end else if (find_start) begin
                        state     <= LOOKUP;
                        req_index <= find_addr[OFFSET_BITS +: INDEX_BITS];
                        req_tag   <= find_addr[ADDR_BITS-1 -: TAG_BITS];
                    end
                end
                LOOKUP: begin
                    done           <= 1'b1;
                    found_in_cache <= hit_any;
                    hit_way        <= hit_sel;
                    hit_data       <= hit_any ? data_array[req_index][hit_sel] : '0;
                    if (hit_any) begin
                        if (cache_hit_count != 16'hFFFF) begin
                            cache_hit_count <= cache_hit_count + 16'd1;
                        end
                    end else if (cache_miss_count != 16'hFFFF) begin
                        cache_miss_count <= cache_miss_count + 16'd1;
                    end
                    state <= IDLE;
                end
                FILL: begin
                    updated                   <= 1'b1;
                    valid[req_index][fill_way] <= 1'b1;
                    evict_valid               <= evicting;
                    evict_tag                 <= evicting ? tags[req_index][victim_way] : '0;
                    state                     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_set_assoc_cache_store.sv
// Directed bench for set_assoc_cache_store: a vector table over set 0x23
// plus hand-written sequences for collisions, reset abort and saturation.
module tb_set_assoc_cache_store;

    logic         clk;
    logic         rst_n;
    logic         ready;
    logic         find_start;
    logic [31:0]  find_addr;
    logic         update_start;
    logic [31:0]  update_addr;
    logic [127:0] block;
    logic         done;
    logic         found_in_cache;
    logic [1:0]   hit_way;
    logic [127:0] hit_data;
    logic         updated;
    logic         evict_valid;
    logic [20:0]  evict_tag;
    logic [15:0]  cache_hit_count;
    logic [15:0]  cache_miss_count;

    int checks;
    int fails;

    set_assoc_cache_store dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ready            (ready),
        .find_start       (find_start),
        .find_addr        (find_addr),
        .update_start     (update_start),
        .update_addr      (update_addr),
        .block            (block),
        .done             (done),
        .found_in_cache   (found_in_cache),
        .hit_way          (hit_way),
        .hit_data         (hit_data),
        .updated          (updated),
        .evict_valid      (evict_valid),
        .evict_tag        (evict_tag),
        .cache_hit_count  (cache_hit_count),
        .cache_miss_count (cache_miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           is_update;
        logic [31:0]  addr;
        logic [127:0] data;
        bit           exp_found;
        logic [1:0]   exp_way;
        logic [127:0] exp_data;
        bit           exp_evict;
        logic [20:0]  exp_evict_tag;
        logic [15:0]  exp_hits;
        logic [15:0]  exp_misses;
    } vec_t;

    localparam int NUM_VECS = 16;
    vec_t vecs [NUM_VECS];

    logic [127:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g, pat_h;

    function automatic vec_t mkVec(input bit is_update, input logic [31:0] addr, input logic [127:0] data,
                                   input bit found, input logic [1:0] way, input logic [127:0] exp_data,
                                   input bit evict, input logic [20:0] etag,
                                   input logic [15:0] hits, input logic [15:0] misses);
        vec_t v;
        v.is_update     = is_update;
        v.addr          = addr;
        v.data          = data;
        v.exp_found     = found;
        v.exp_way       = way;
        v.exp_data      = exp_data;
        v.exp_evict     = evict;
        v.exp_evict_tag = etag;
        v.exp_hits      = hits;
        v.exp_misses    = misses;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one request at a negedge and returns at the negedge of the result cycle.
    task automatic applyStimulus(input bit is_update, input logic [31:0] addr, input logic [127:0] data);
        checkOutput("ready_before_req", 128'(ready), 128'(1));
        if (is_update) begin
            update_start = 1'b1;
            update_addr  = addr;
            block        = data;
        end else begin
            find_start = 1'b1;
            find_addr  = addr;
        end
        @(posedge clk);
        @(negedge clk);
        find_start   = 1'b0;
        update_start = 1'b0;
        checkOutput("busy_during_req", 128'(ready), 128'(0));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkResetOutputs(input string tag_name);
        checkOutput({tag_name, "_ready"},  128'(ready), 128'(1));
        checkOutput({tag_name, "_done"},   128'(done), 128'(0));
        checkOutput({tag_name, "_updated"}, 128'(updated), 128'(0));
        checkOutput({tag_name, "_found"},  128'(found_in_cache), 128'(0));
        checkOutput({tag_name, "_hitway"}, 128'(hit_way), 128'(0));
        checkOutput({tag_name, "_hitdata"}, hit_data, 128'(0));
        checkOutput({tag_name, "_evict"},  128'(evict_valid), 128'(0));
        checkOutput({tag_name, "_evtag"},  128'(evict_tag), 128'(0));
        checkOutput({tag_name, "_hits"},   128'(cache_hit_count), 128'(0));
        checkOutput({tag_name, "_misses"}, 128'(cache_miss_count), 128'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks       = 0;
        fails        = 0;
        rst_n        = 1'b0;
        find_start   = 1'b0;
        find_addr    = '0;
        update_start = 1'b0;
        update_addr  = '0;
        block        = '0;

        pat_a = {16{8'hAA}};
        pat_b = {16{8'hBB}};
        pat_c = {16{8'hCC}};
        pat_d = {16{8'hDD}};
        pat_e = {8{16'hE1E2}};
        pat_f = {4{32'h0F1E2D3C}};
        pat_g = {2{64'h0123456789ABCDEF}};
        pat_h = {16{8'h5A}};

        // Set 0x23; tags 0x0230->0, 0x1230->2, 0x1A30->3, 0x2230->4, 0x2A30->5, 0x3230->6.
        vecs[0]  = mkVec(0, 32'h1230, '0,    0, 2'd0, '0,    0, 21'd0, 16'd0, 16'd1);
        vecs[1]  = mkVec(1, 32'h1230, pat_a, 0, 2'd0, '0,    0, 21'd0, 16'd0, 16'd1);
        vecs[2]  = mkVec(0, 32'h1230, '0,    1, 2'd0, pat_a, 0, 21'd0, 16'd1, 16'd1);
        vecs[3]  = mkVec(1, 32'h1A30, pat_b, 0, 2'd0, '0,    0, 21'd0, 16'd1, 16'd1);
        vecs[4]  = mkVec(1, 32'h2230, pat_c, 0, 2'd0, '0,    0, 21'd0, 16'd1, 16'd1);
        vecs[5]  = mkVec(1, 32'h2A30, pat_d, 0, 2'd0, '0,    0, 21'd0, 16'd1, 16'd1);
        vecs[6]  = mkVec(0, 32'h1230, '0,    1, 2'd0, pat_a, 0, 21'd0, 16'd2, 16'd1);
        vecs[7]  = mkVec(1, 32'h3230, pat_e, 0, 2'd0, '0,    1, 21'd3, 16'd2, 16'd1);
        vecs[8]  = mkVec(0, 32'h1A30, '0,    0, 2'd0, '0,    0, 21'd0, 16'd2, 16'd2);
        vecs[9]  = mkVec(0, 32'h3230, '0,    1, 2'd1, pat_e, 0, 21'd0, 16'd3, 16'd2);
        vecs[10] = mkVec(1, 32'h2230, pat_f, 0, 2'd0, '0,    0, 21'd0, 16'd3, 16'd2);
        vecs[11] = mkVec(0, 32'h2238, '0,    1, 2'd2, pat_f, 0, 21'd0, 16'd4, 16'd2);
        vecs[12] = mkVec(1, 32'h0230, pat_g, 0, 2'd0, '0,    1, 21'd5, 16'd4, 16'd2);
        vecs[13] = mkVec(0, 32'h2A30, '0,    0, 2'd0, '0,    0, 21'd0, 16'd4, 16'd3);
        vecs[14] = mkVec(0, 32'h0040, '0,    0, 2'd0, '0,    0, 21'd0, 16'd4, 16'd4);
        vecs[15] = mkVec(0, 32'h0230, '0,    1, 2'd3, pat_g, 0, 21'd0, 16'd5, 16'd4);

        #12;
        checkResetOutputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].is_update, vecs[i].addr, vecs[i].data);
            checkOutput($sformatf("v%0d_ready", i), 128'(ready), 128'(1));
            if (vecs[i].is_update) begin
                checkOutput($sformatf("v%0d_updated", i), 128'(updated), 128'(1));
                checkOutput($sformatf("v%0d_done", i), 128'(done), 128'(0));
                checkOutput($sformatf("v%0d_evict", i), 128'(evict_valid), 128'(vecs[i].exp_evict));
                if (vecs[i].exp_evict)
                    checkOutput($sformatf("v%0d_evtag", i), 128'(evict_tag), 128'(vecs[i].exp_evict_tag));
            end else begin
                checkOutput($sformatf("v%0d_done", i), 128'(done), 128'(1));
                checkOutput($sformatf("v%0d_updated", i), 128'(updated), 128'(0));
                checkOutput($sformatf("v%0d_found", i), 128'(found_in_cache), 128'(vecs[i].exp_found));
                if (vecs[i].exp_found)
                    checkOutput($sformatf("v%0d_hitway", i), 128'(hit_way), 128'(vecs[i].exp_way));
                checkOutput($sformatf("v%0d_hitdata", i), hit_data, vecs[i].exp_data);
            end
            checkOutput($sformatf("v%0d_hits", i), 128'(cache_hit_count), 128'(vecs[i].exp_hits));
            checkOutput($sformatf("v%0d_misses", i), 128'(cache_miss_count), 128'(vecs[i].exp_misses));
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_fell", i), 128'(done), 128'(0));
            checkOutput($sformatf("v%0d_updated_fell", i), 128'(updated), 128'(0));
        end

        // Simultaneous requests: fill of tag 5 evicts way 0 (tag 2), then the held find hits it.
        update_start = 1'b1;
        update_addr  = 32'h2A30;
        block        = pat_h;
        find_start   = 1'b1;
        find_addr    = 32'h2A30;
        @(posedge clk);
        @(negedge clk);
        update_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("both_updated_first", 128'(updated), 128'(1));
        checkOutput("both_no_done_yet", 128'(done), 128'(0));
        checkOutput("both_evict", 128'(evict_valid), 128'(1));
        checkOutput("both_evtag", 128'(evict_tag), 128'(2));
        @(posedge clk);
        @(negedge clk);
        find_start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("both_find_done", 128'(done), 128'(1));
        checkOutput("both_find_found", 128'(found_in_cache), 128'(1));
        checkOutput("both_find_way", 128'(hit_way), 128'(0));
        checkOutput("both_find_data", hit_data, pat_h);
        checkOutput("both_find_hits", 128'(cache_hit_count), 128'(6));
        @(negedge clk);

        // Reset dropped while a lookup is in flight aborts it and invalidates every line.
        find_start = 1'b1;
        find_addr  = 32'h2A30;
        @(posedge clk);
        @(negedge clk);
        find_start = 1'b0;
        rst_n      = 1'b0;
        #1;
        checkResetOutputs("midrst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("midrst_no_done", 128'(done), 128'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 32'h2A30, '0);
        checkOutput("postrst_found", 128'(found_in_cache), 128'(0));
        checkOutput("postrst_misses", 128'(cache_miss_count), 128'(1));
        @(negedge clk);
        applyStimulus(1'b0, 32'h0230, '0);
        checkOutput("postrst_found2", 128'(found_in_cache), 128'(0));
        checkOutput("postrst_misses2", 128'(cache_miss_count), 128'(2));
        checkOutput("postrst_hits", 128'(cache_hit_count), 128'(0));
        @(negedge clk);

        // Miss counter saturation, preset just below the ceiling.
        force dut.cache_miss_count = 16'hFFFE;
        @(negedge clk);
        release dut.cache_miss_count;
        @(negedge clk);
        applyStimulus(1'b0, 32'h1230, '0);
        checkOutput("sat_reach", 128'(cache_miss_count), 128'(16'hFFFF));
        @(negedge clk);
        applyStimulus(1'b0, 32'h1A30, '0);
        checkOutput("sat_hold", 128'(cache_miss_count), 128'(16'hFFFF));
        checkOutput("sat_done", 128'(done), 128'(1));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
